// File: rtl/cc_fetch_and_inject_if.sv
// Handshake bundles used by cc_fetch_and_inject.
//   memory_read_iface : word read port. Master drives addr/valid and receives
//                       ready/data; data is returned the cycle after the
//                       valid/ready handshake.
//   channel_iface     : injection channel. Master drives data/valid and
//                       receives ready/latency.
interface memory_read_iface #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output addr, valid, input ready, data);
  modport slave  (input addr, valid, output ready, data);
endinterface

interface channel_iface #(
  parameter int DATA_WIDTH    = 9,
  parameter int LATENCY_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]    data;
  logic                     valid;
  logic                     ready;
  logic [LATENCY_WIDTH-1:0] latency;

  modport master (output data, valid, input ready, latency);
  modport slave  (input data, valid, output ready, latency);
endinterface

// File: rtl/cc_fetch_and_inject.sv
// Coprocessor front end: walks a string in memory one character at a time,
// injects START_PC tagged with character parity into the mesh for each
// character, and waits for the mesh to drain that character before moving on.
// Reports match/no-match on completion.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_start                   one-cycle start pulse (ignored while busy)
//   i_base_addr, i_str_len    word address of character 0, character count
//   memory_cc                 character fetch port (master)
//   override                  PC injection channel (master), latency unused
//   o_cur_cc                  current character
//   o_cur_is_even_character   parity of current index (1 = even)
//   o_enable                  mesh enable
//   i_any_bb_accept           OR of basic-block accepts
//   i_cur_char_done           mesh has drained the current parity
//   o_busy, o_done            run in progress / one-cycle completion pulse
//   o_accepted, o_match_index match result and index of accepting character
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | memory request for the word holding idx
// WAIT_DATA | read data returns; latch word and current character
// INJECT    | offer {parity, START_PC} on the override channel
// EXEC      | mesh running the current character
// DONE      | one-cycle completion pulse
module cc_fetch_and_inject #(
  parameter int                    PC_WIDTH          = 8,
  parameter int                    CHARACTER_WIDTH   = 8,
  parameter int                    MEMORY_WIDTH      = 16,
  parameter int                    MEMORY_ADDR_WIDTH = 11,
  parameter logic [PC_WIDTH-1:0]   START_PC          = '0,
  parameter int                    LEN_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic [MEMORY_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]         i_str_len,
  memory_read_iface.master             memory_cc,
  channel_iface.master                 override,
  output logic [CHARACTER_WIDTH-1:0]   o_cur_cc,
  output logic                         o_cur_is_even_character,
  output logic                         o_enable,
  input  logic                         i_any_bb_accept,
  input  logic                         i_cur_char_done,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_accepted,
  output logic [LEN_WIDTH-1:0]         o_match_index
);

  localparam int CPW    = MEMORY_WIDTH / CHARACTER_WIDTH;
  localparam int LANE_W = (CPW > 1) ? $clog2(CPW) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WAIT_DATA, ST_INJECT, ST_EXEC, ST_DONE
  } state_t;

  state_t                                  r_state, w_next_state;
  logic [MEMORY_ADDR_WIDTH-1:0]            r_addr;
  logic [LEN_WIDTH-1:0]                    r_idx, r_str_len, r_match_index;
  logic                                    r_parity, r_accepted;
  logic [CPW-1:0][CHARACTER_WIDTH-1:0]     r_word;
  logic [CHARACTER_WIDTH-1:0]              r_cur_cc;

  logic [CPW-1:0][CHARACTER_WIDTH-1:0]     w_mem_lanes;
  logic [LEN_WIDTH-1:0]                    w_next_idx;
  logic [LANE_W-1:0]                       w_cur_lane, w_next_lane;
  logic                                    w_last;

  assign w_mem_lanes = memory_cc.data;
  assign w_next_idx  = r_idx + LEN_WIDTH'(1);
  assign w_cur_lane  = LANE_W'(r_idx % LEN_WIDTH'(CPW));
  assign w_next_lane = LANE_W'(w_next_idx % LEN_WIDTH'(CPW));
  assign w_last      = (r_idx == r_str_len - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Accept is checked before the handshake/done inputs so it wins over both.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:      if (i_start) w_next_state = (i_str_len == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH:     if (memory_cc.ready) w_next_state = ST_WAIT_DATA;
      ST_WAIT_DATA: w_next_state = ST_INJECT;
      ST_INJECT: begin
        if (i_any_bb_accept)     w_next_state = ST_DONE;
        else if (override.ready) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (i_any_bb_accept)       w_next_state = ST_DONE;
        else if (i_cur_char_done) begin
          if (w_last)                    w_next_state = ST_DONE;
          else if (w_next_lane == '0)    w_next_state = ST_FETCH;
          else                           w_next_state = ST_INJECT;
        end
      end
      ST_DONE:      w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_idx         <= '0;
      r_str_len     <= '0;
      r_parity      <= 1'b1;
      r_word        <= '0;
      r_cur_cc      <= '0;
      r_accepted    <= 1'b0;
      r_match_index <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_accepted <= 1'b0;
            r_str_len  <= i_str_len;
            r_addr     <= i_base_addr;
            r_idx      <= '0;
            r_parity   <= 1'b1;
          end
        end
        ST_WAIT_DATA: begin
          r_word   <= memory_cc.data;
          r_cur_cc <= w_mem_lanes[w_cur_lane];
        end
        ST_INJECT: begin
          if (i_any_bb_accept) begin
            r_accepted    <= 1'b1;
            r_match_index <= r_idx;
          end
        end
        ST_EXEC: begin
          if (i_any_bb_accept) begin
            r_accepted    <= 1'b1;
            r_match_index <= r_idx;
          end else if (i_cur_char_done && !w_last) begin
            r_idx    <= w_next_idx;
            r_parity <= ~r_parity;
            // Crossing into a new word fetches it; otherwise the next lane
            // comes straight from the latched word.
            if (w_next_lane == '0) r_addr   <= r_addr + MEMORY_ADDR_WIDTH'(1);
            else                   r_cur_cc <= r_word[w_next_lane];
          end
        end
        default: ;
      endcase
    end
  end

  assign memory_cc.addr          = r_addr;
  assign memory_cc.valid         = (r_state == ST_FETCH);
  assign override.valid          = (r_state == ST_INJECT);
  assign override.data           = {r_parity, START_PC};
  assign o_cur_cc                = r_cur_cc;
  assign o_cur_is_even_character = r_parity;
  assign o_enable                = (r_state == ST_INJECT) || (r_state == ST_EXEC);
  assign o_busy                  = (r_state != ST_IDLE);
  assign o_done                  = (r_state == ST_DONE);
  assign o_accepted              = r_accepted;
  assign o_match_index           = r_match_index;

endmodule
